mlaccel_insn_fetch: RTL and testbench

Instruction sequencer between the command state machine and the compute core. On start it fetches 32-bit instructions from main memory over the smem port into a small prefetch FIFO. It executes the control-flow instructions JUMP, SETLC, LOOP and HALT locally and forwards every other instruction to compute through a valid/ready handshake. Asserts busy from start until the program halts or is stopped and no memory read is outstanding.

---
 rtl/mlaccel_insn_fetch.sv | 189 ++++++++++++++++++
 tb/tb_mlaccel_insn_fetch.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlaccel_insn_fetch.sv
// Instruction sequencer: prefetches program words from smem, executes JUMP/SETLC/LOOP/HALT
// locally and hands every other instruction to the compute core over valid/ready.
//
// state | meaning
// IDLE  | waiting for start; FIFO empty, no read outstanding
// RUN   | fetching into the prefetch FIFO and processing the head entry
// DRAIN | program halted or stopped; waiting for the last read to come back
module mlaccel_insn_fetch #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              smem_valid,
    input  logic              smem_ready,
    output logic [ADDR_W-1:0] smem_addr,
    input  logic [31:0]       smem_data,
    output logic              comp_valid,
    input  logic              comp_ready,
    output logic [31:0]       comp_insn
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] OP_JUMP  = 6'h01;
    localparam logic [5:0] OP_SETLC = 6'h02;
    localparam logic [5:0] OP_LOOP  = 6'h03;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    function automatic logic f_is_ctrl(input logic [5:0] op);
        return (op == OP_JUMP) || (op == OP_SETLC) || (op == OP_LOOP) || (op == OP_HALT);
    endfunction

    state_t            r_state;
    logic [31:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_pend;
    logic              r_discard;
    logic              r_halt_seen;
    logic              r_smem_valid;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [15:0]       r_lc;
    logic              r_comp_valid;
    logic [31:0]       r_comp_insn;

    logic [31:0]       w_head;
    logic [31:0]       w_next;
    logic [ADDR_W-1:0] w_target;
    logic              w_run;
    logic              w_start;
    logic              w_stop_run;
    logic              w_accept;
    logic              w_head_act;
    logic              w_head_ctrl;
    logic              w_setlc;
    logic              w_loop_fall;
    logic              w_loop_taken;
    logic              w_jump;
    logic              w_halt;
    logic              w_redirect;
    logic              w_flush;
    logic              w_clear;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_halt_next;
    logic [CNT_W-1:0]  w_count_next;
    state_t            w_state_next;

    assign w_head   = r_fifo[r_rd_ptr];
    assign w_next   = r_fifo[r_rd_ptr + PTR_W'(1)];
    assign w_target = ADDR_W'(w_head[31:16]);

    assign w_run      = (r_state == S_RUN) && !stop;
    assign w_start    = (r_state == S_IDLE) && start && !stop;
    assign w_stop_run = (r_state == S_RUN) && stop;
    assign w_accept   = r_comp_valid && comp_ready;

    // While comp_valid is up the head is the offered word, so control words only run when it is low.
    assign w_head_act   = w_run && !r_comp_valid && (r_count != '0);
    assign w_head_ctrl  = w_head_act && f_is_ctrl(w_head[5:0]);
    assign w_jump       = w_head_ctrl && (w_head[5:0] == OP_JUMP);
    assign w_setlc      = w_head_ctrl && (w_head[5:0] == OP_SETLC);
    assign w_loop_taken = w_head_ctrl && (w_head[5:0] == OP_LOOP) && (r_lc != 16'd0);
    assign w_loop_fall  = w_head_ctrl && (w_head[5:0] == OP_LOOP) && (r_lc == 16'd0);
    assign w_halt       = w_head_ctrl && (w_head[5:0] == OP_HALT);
    assign w_redirect   = w_jump || w_loop_taken;
    assign w_flush      = w_redirect || w_halt || w_stop_run;
    assign w_clear      = w_flush || w_start;

    assign w_push = (r_state == S_RUN) && smem_ready && r_pend && !r_discard && !w_flush;
    assign w_pop  = w_run && (w_accept || w_setlc || w_loop_fall);

    assign w_count_next = w_clear ? '0 : (r_count + CNT_W'(w_push) - CNT_W'(w_pop));
    // A HALT already in the FIFO ends prefetching so nothing past it is ever read.
    assign w_halt_next  = w_clear ? 1'b0 : (r_halt_seen || (w_push && (smem_data[5:0] == OP_HALT)));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_RUN;
            S_RUN:   if (w_stop_run || w_halt) w_state_next = S_DRAIN;
            S_DRAIN: if (!r_pend || smem_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_issue = (w_state_next == S_RUN) && (!r_pend || smem_ready) && !w_halt_next
                     && (w_count_next < CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_pend       <= 1'b0;
            r_discard    <= 1'b0;
            r_halt_seen  <= 1'b0;
            r_smem_valid <= 1'b0;
            r_fetch_pc   <= '0;
            r_lc         <= 16'd0;
            r_comp_valid <= 1'b0;
            r_comp_insn  <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_halt_seen <= w_halt_next;

            if (w_clear) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            if (w_issue)         r_pend <= 1'b1;
            else if (smem_ready) r_pend <= 1'b0;

            if (w_issue)                    r_smem_valid <= 1'b1;
            else if (smem_ready || w_flush) r_smem_valid <= 1'b0;

            // A read in flight across a redirect or abort belongs to the old stream.
            if (w_flush && r_pend && !smem_ready) r_discard <= 1'b1;
            else if (smem_ready)                  r_discard <= 1'b0;

            if (w_start)         r_fetch_pc <= addr;
            else if (w_redirect) r_fetch_pc <= w_target;
            else if (w_push)     r_fetch_pc <= r_fetch_pc + ADDR_W'(1);

            if (w_setlc)           r_lc <= w_head[31:16];
            else if (w_loop_taken) r_lc <= r_lc - 16'd1;

            if (stop) begin
                r_comp_valid <= 1'b0;
            end else if (w_accept) begin
                if ((r_count > CNT_W'(1)) && !f_is_ctrl(w_next[5:0])) begin
                    r_comp_insn <= w_next;
                end else begin
                    r_comp_valid <= 1'b0;
                end
            end else if (w_head_act && !f_is_ctrl(w_head[5:0])) begin
                r_comp_valid <= 1'b1;
                r_comp_insn  <= w_head;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_fifo[r_wr_ptr] <= smem_data;
    end

    assign busy       = (r_state != S_IDLE);
    assign smem_valid = r_smem_valid;
    assign smem_addr  = r_fetch_pc;
    assign comp_valid = r_comp_valid;
    assign comp_insn  = r_comp_insn;

endmodule

// File: tb/tb_mlaccel_insn_fetch.sv
// Bench for mlaccel_insn_fetch: random-latency memory, random compute backpressure and an
// instruction-level interpreter that predicts the forwarded instruction stream.
module tb_mlaccel_insn_fetch;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 16;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] addr = 16'd0;
    logic        busy;
    logic        smem_valid;
    logic        smem_ready = 1'b0;
    logic [15:0] smem_addr;
    logic [31:0] smem_data = 32'd0;
    logic        comp_valid;
    logic        comp_ready = 1'b0;
    logic [31:0] comp_insn;

    always #5 clock = ~clock;

    mlaccel_insn_fetch #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .stop       (stop),
        .addr       (addr),
        .busy       (busy),
        .smem_valid (smem_valid),
        .smem_ready (smem_ready),
        .smem_addr  (smem_addr),
        .smem_data  (smem_data),
        .comp_valid (comp_valid),
        .comp_ready (comp_ready),
        .comp_insn  (comp_insn)
    );

    bit   [31:0] mem [0:65535];
    int          n_checks = 0;
    int          n_pass = 0;
    int          mem_reads = 0;
    int          mem_lat_max = 2;
    int          mem_lat = 0;
    bit          mem_pending = 1'b0;
    logic [15:0] mem_req_addr = 16'd0;
    int          addr_viol = 0;
    int          insn_viol = 0;
    int          rdy_mode = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [15:0] model_lc = 16'd0;
    logic        sk_pv = 1'b0;
    logic        sk_pa = 1'b0;
    logic [31:0] sk_pi = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [15:0] tgt);
        return {tgt, 10'd0, op};
    endfunction

    function automatic logic [31:0] rnd_compute();
        logic [5:0] op;
        op = 6'($urandom_range(62, 4));
        return {16'($urandom), 10'($urandom), op};
    endfunction

    // Memory: accepts a request on the first cycle smem_valid is seen, answers later with one pulse.
    initial forever begin
        @(negedge clock);
        if (!resetn) begin
            smem_ready  = 1'b0;
            mem_pending = 1'b0;
        end else begin
            smem_ready = 1'b0;
            if (mem_pending) begin
                if (smem_valid && (smem_addr !== mem_req_addr)) addr_viol++;
                if (mem_lat == 0) begin
                    smem_ready  = 1'b1;
                    smem_data   = mem[mem_req_addr];
                    mem_pending = 1'b0;
                end else begin
                    mem_lat--;
                end
            end else if (smem_valid) begin
                mem_req_addr = smem_addr;
                mem_lat      = int'($urandom_range(mem_lat_max, 0));
                mem_pending  = 1'b1;
                mem_reads++;
            end
        end
    end

    // Compute sink: drives comp_ready and logs every completed transfer.
    initial forever begin
        @(negedge clock);
        case (rdy_mode)
            0:       comp_ready = 1'b1;
            1:       comp_ready = ($urandom_range(3, 0) != 0);
            default: comp_ready = 1'b0;
        endcase
        if (!resetn) begin
            sk_pv = 1'b0;
        end else begin
            if (sk_pv && !sk_pa && comp_valid && (comp_insn !== sk_pi)) insn_viol++;
            if (comp_valid && comp_ready) got_q.push_back(comp_insn);
            sk_pv = comp_valid;
            sk_pi = comp_insn;
            sk_pa = comp_ready;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Reference: execute the program instruction by instruction.
    task automatic model_run(input logic [15:0] entry);
        logic [15:0] pc;
        logic [31:0] w;
        pc = entry;
        exp_q.delete();
        for (int s = 0; s < 2000; s++) begin
            w = mem[pc];
            if (w[5:0] == 6'h3F) break;
            case (w[5:0])
                6'h01: pc = w[31:16];
                6'h02: begin model_lc = w[31:16]; pc = pc + 16'd1; end
                6'h03: begin
                    if (model_lc != 16'd0) begin
                        model_lc = model_lc - 16'd1;
                        pc = w[31:16];
                    end else begin
                        pc = pc + 16'd1;
                    end
                end
                default: begin exp_q.push_back(w); pc = pc + 16'd1; end
            endcase
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
    endtask

    task automatic load_straight();
        for (int i = 0; i < 3; i++) mem[16'h10 + i] = mk(6'h10, 16'h10 + 16'(i));
        mem[16'h13] = mk(6'h3F, 16'h0);
    endtask

    task automatic start_prog(input string tag, input logic [15:0] entry);
        got_q.delete();
        model_run(entry);
        addr  = entry;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, "_busy_rise"}, 32'(busy), 32'd1);
    endtask

    task automatic finish_prog(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check_eq({tag, "_busy_fall"}, 32'(busy), 32'd0);
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check_eq($sformatf("%s_insn%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    function automatic int count_of(input logic [31:0] w);
        int c;
        c = 0;
        foreach (got_q[i]) if (got_q[i] == w) c++;
        return c;
    endfunction

    initial begin
        int n;
        logic [15:0] base;
        int k;
        clear_mem();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_smem_valid", 32'(smem_valid), 32'd0);
        check_eq("rst_smem_addr", 32'(smem_addr), 32'd0);
        check_eq("rst_comp_valid", 32'(comp_valid), 32'd0);
        check_eq("rst_comp_insn", comp_insn, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // start and stop together in IDLE: nothing happens
        mem_reads = 0;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tick();
        check_eq("startstop_busy", 32'(busy), 32'd0);
        check_eq("startstop_reads", 32'(mem_reads), 32'd0);

        // straight line
        load_straight();
        mem_reads = 0;
        rdy_mode = 0;
        start_prog("line", 16'h10);
        finish_prog("line");
        check_eq("line_reads", 32'(mem_reads), 32'd4);

        // backpressure on a longer straight program
        clear_mem();
        for (int i = 0; i < 8; i++) mem[16'h10 + i] = mk(6'h10, 16'h100 + 16'(i));
        mem[16'h18] = mk(6'h3F, 16'h0);
        mem_lat_max = 1;
        mem_reads = 0;
        rdy_mode = 2;
        start_prog("bp", 16'h10);
        repeat (20) tick();
        check_eq("bp_hold_reads", 32'(mem_reads), 32'(FIFO_DEPTH));
        check_eq("bp_hold_smem_valid", 32'(smem_valid), 32'd0);
        check_eq("bp_hold_comp_valid", 32'(comp_valid), 32'd1);
        check_eq("bp_hold_transfers", 32'(got_q.size()), 32'd0);
        rdy_mode = 1;
        finish_prog("bp");
        mem_lat_max = 2;

        // counted loop
        clear_mem();
        mem[0] = mk(6'h02, 16'd2);
        mem[1] = mk(6'h10, 16'hAAAA);
        mem[2] = mk(6'h03, 16'h1);
        mem[3] = mk(6'h3F, 16'h0);
        rdy_mode = 1;
        start_prog("loop", 16'h0);
        finish_prog("loop");
        check_eq("loop_a_times", 32'(count_of(mk(6'h10, 16'hAAAA))), 32'd3);

        // jump with a read in flight
        clear_mem();
        mem[16'h00] = mk(6'h01, 16'h40);
        mem[16'h01] = mk(6'h11, 16'hBBBB);
        mem[16'h40] = mk(6'h12, 16'hCCCC);
        mem[16'h41] = mk(6'h3F, 16'h0);
        rdy_mode = 0;
        start_prog("jump", 16'h0);
        finish_prog("jump");
        check_eq("jump_b_times", 32'(count_of(mk(6'h11, 16'hBBBB))), 32'd0);
        check_eq("jump_c_times", 32'(count_of(mk(6'h12, 16'hCCCC))), 32'd1);

        // random programs: SETLC n, k computes, LOOP back, JUMP over junk, compute, HALT
        for (int r = 0; r < 6; r++) begin
            base = 16'h200 + 16'(r * 16'h100);
            k = int'($urandom_range(4, 1));
            mem[base] = mk(6'h02, 16'($urandom_range(3, 0)));
            for (int j = 0; j < k; j++) mem[base + 16'(1 + j)] = rnd_compute();
            mem[base + 16'(1 + k)] = mk(6'h03, base + 16'd1);
            mem[base + 16'(2 + k)] = mk(6'h01, base + 16'h40);
            for (int j = 3; j < 9; j++) mem[base + 16'(j + k)] = rnd_compute();
            mem[base + 16'h40] = rnd_compute();
            mem[base + 16'h41] = mk(6'h3F, 16'h0);
            mem_lat_max = int'($urandom_range(3, 0));
            rdy_mode = 1;
            start_prog($sformatf("rnd%0d", r), base);
            finish_prog($sformatf("rnd%0d", r));
        end

        // stop while a read is outstanding on a jump-to-self loop
        clear_mem();
        mem[0] = mk(6'h01, 16'h0);
        mem_lat_max = 3;
        rdy_mode = 0;
        start_prog("stop", 16'h0);
        n = 0;
        while (!(mem_pending && mem_lat >= 1) && n < 200) begin
            tick();
            n++;
        end
        check_eq("stop_found_pending", 32'(mem_pending && mem_lat >= 1), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("stop_smem_valid", 32'(smem_valid), 32'd0);
        check_eq("stop_drain_busy", 32'(busy), 32'd1);
        n = 0;
        while (!smem_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq("stop_resp_seen", 32'(smem_ready), 32'd1);
        tick();
        check_eq("stop_idle", 32'(busy), 32'd0);
        check_eq("stop_no_transfers", 32'(got_q.size()), 32'd0);
        load_straight();
        mem_reads = 0;
        start_prog("after_stop", 16'h10);
        finish_prog("after_stop");
        check_eq("after_stop_reads", 32'(mem_reads), 32'd4);

        // async reset with comp_valid up and a read outstanding
        clear_mem();
        for (int i = 0; i < 10; i++) mem[16'h80 + i] = mk(6'h20, 16'h80 + 16'(i));
        mem[16'h8A] = mk(6'h3F, 16'h0);
        mem_lat_max = 2;
        rdy_mode = 2;
        start_prog("rst", 16'h80);
        n = 0;
        while (!(comp_valid && mem_pending) && n < 50) begin
            tick();
            n++;
        end
        check_eq("rst_setup", 32'(comp_valid && mem_pending), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_smem_valid", 32'(smem_valid), 32'd0);
        check_eq("arst_smem_addr", 32'(smem_addr), 32'd0);
        check_eq("arst_comp_valid", 32'(comp_valid), 32'd0);
        check_eq("arst_comp_insn", comp_insn, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        model_lc = 16'd0;
        rdy_mode = 0;
        tick();
        load_straight();
        mem_reads = 0;
        start_prog("post_rst", 16'h10);
        finish_prog("post_rst");
        check_eq("post_rst_reads", 32'(mem_reads), 32'd4);

        check_eq("smem_addr_stable", 32'(addr_viol), 32'd0);
        check_eq("comp_insn_stable", 32'(insn_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
